path_follower: RTL and testbench

//   Consumer end of the planner's final_path bus. Captures a packed path on

---
 rtl/path_follower.sv | 218 +++++++++++++++++++++
 tb/tb_path_follower.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_follower.sv
// path_follower
//   Consumer end of the planner's final_path bus. On path_valid (IDLE only) the
//   packed path is copied into a local buffer, scanned one entry per cycle for
//   the sentinel to find its length, then replayed start-first as waypoints
//   over a valid/ready handshake. An unacknowledged waypoint times out into an
//   error, and abort drops the path silently.
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   path_valid   in   capture strobe, honoured in IDLE only
//   path_in      in   MAX_WP entries, entry i at [i*NODE_W +: NODE_W];
//                     entry 0 is the end node, entry k+1 precedes entry k
//   abort        in   cancel the path in SCAN/EMIT (no done, no err)
//   wp_ready     in   downstream accepts the presented waypoint
//   wp_valid     out  wp_node/wp_index/wp_last are valid
//   wp_node      out  current waypoint node ID
//   wp_index     out  0 = start node, +1 per waypoint
//   wp_last      out  current waypoint is the end node
//   path_len     out  length found by the last successful scan
//   busy         out  state != IDLE
//   follow_done  out  one-cycle pulse after the last waypoint is accepted
//   err          out  one-cycle pulse on error
//   err_code     out  01 empty, 10 bad node, 11 timeout; held until next err
//
// state  | meaning
// IDLE   | waiting for path_valid
// SCAN   | checking buffer entry idx for sentinel / illegal ID
// EMIT   | presenting waypoint buf[ptr], counting unacknowledged cycles
// DONE   | follow_done pulse
// ERR    | err pulse with err_code
module path_follower #(
  parameter int NODE_W   = 5,
  parameter int MAX_WP   = 10,
  parameter int SENTINEL = 27,
  parameter int MAX_NODE = 25,
  parameter int TIMEOUT  = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     path_valid,
  input  logic [MAX_WP*NODE_W-1:0] path_in,
  input  logic                     abort,
  input  logic                     wp_ready,
  output logic                     wp_valid,
  output logic [NODE_W-1:0]        wp_node,
  output logic [3:0]               wp_index,
  output logic                     wp_last,
  output logic [3:0]               path_len,
  output logic                     busy,
  output logic                     follow_done,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int                TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]        LAST_IDX = 4'(MAX_WP - 1);
  localparam logic [NODE_W-1:0] SENT_ID  = NODE_W'(SENTINEL);
  localparam logic [NODE_W-1:0] MAX_ID   = NODE_W'(MAX_NODE);
  localparam logic [TW-1:0]     TC_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [NODE_W-1:0] path_buf [MAX_WP];
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic              wp_valid_d;
  logic [NODE_W-1:0] wp_node_d;
  logic [3:0]        wp_index_d;
  logic              wp_last_d;
  logic [3:0]        path_len_d;
  logic              follow_done_d;
  logic              err_d;
  logic [1:0]        err_code_d;

  logic              load_buf;
  logic [NODE_W-1:0] entry;
  logic              is_sent;
  logic [3:0]        scan_len;

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    tcnt_d        = tcnt_q;
    wp_valid_d    = 1'b0;
    wp_node_d     = '0;
    wp_index_d    = '0;
    wp_last_d     = 1'b0;
    path_len_d    = path_len;
    follow_done_d = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code;
    load_buf      = 1'b0;
    entry         = path_buf[idx_q];
    is_sent       = (entry == SENT_ID);
    // Sentinel at idx means idx entries precede it; a legal entry in the last
    // slot means the path fills the whole bus.
    scan_len      = is_sent ? idx_q : idx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (path_valid) begin
          load_buf = 1'b1;
          idx_d    = '0;
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (is_sent && idx_q == '0) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if (!is_sent && entry > MAX_ID) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else if (is_sent || idx_q == LAST_IDX) begin
          // First waypoint is registered on the same edge as entering EMIT.
          state_d    = S_EMIT;
          path_len_d = scan_len;
          ptr_d      = scan_len - 4'd1;
          tcnt_d     = '0;
          wp_valid_d = 1'b1;
          wp_node_d  = path_buf[scan_len - 4'd1];
          wp_index_d = '0;
          wp_last_d  = (scan_len == 4'd1);
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      S_EMIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wp_ready) begin
          if (ptr_q == '0) begin
            state_d       = S_DONE;
            follow_done_d = 1'b1;
          end else begin
            ptr_d      = ptr_q - 4'd1;
            tcnt_d     = '0;
            wp_valid_d = 1'b1;
            wp_node_d  = path_buf[ptr_q - 4'd1];
            wp_index_d = wp_index + 4'd1;
            wp_last_d  = (ptr_q == 4'd1);
          end
        end else if (tcnt_q == TC_LAST) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end else begin
          tcnt_d     = tcnt_q + TW'(1);
          wp_valid_d = 1'b1;
          wp_node_d  = wp_node;
          wp_index_d = wp_index;
          wp_last_d  = wp_last;
        end
      end

      S_DONE: state_d = S_IDLE;

      S_ERR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      tcnt_q      <= '0;
      wp_valid    <= 1'b0;
      wp_node     <= '0;
      wp_index    <= '0;
      wp_last     <= 1'b0;
      path_len    <= '0;
      follow_done <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      for (int i = 0; i < MAX_WP; i++) path_buf[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      tcnt_q      <= tcnt_d;
      wp_valid    <= wp_valid_d;
      wp_node     <= wp_node_d;
      wp_index    <= wp_index_d;
      wp_last     <= wp_last_d;
      path_len    <= path_len_d;
      follow_done <= follow_done_d;
      err         <= err_d;
      err_code    <= err_code_d;
      if (load_buf) begin
        for (int i = 0; i < MAX_WP; i++)
          path_buf[i] <= path_in[i*NODE_W +: NODE_W];
      end
    end
  end

endmodule

// File: tb/tb_path_follower.sv
module tb_path_follower;
  localparam int NODE_W   = 5;
  localparam int MAX_WP   = 10;
  localparam int SENTINEL = 27;
  localparam int MAX_NODE = 25;
  localparam int TIMEOUT  = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     path_valid = 1'b0;
  logic [MAX_WP*NODE_W-1:0] path_in = '0;
  logic                     abort = 1'b0;
  logic                     wp_ready = 1'b0;
  logic                     wp_valid;
  logic [NODE_W-1:0]        wp_node;
  logic [3:0]               wp_index;
  logic                     wp_last;
  logic [3:0]               path_len;
  logic                     busy;
  logic                     follow_done;
  logic                     err;
  logic [1:0]               err_code;

  int vec = 0;
  int errs = 0;
  int last_len = 0;
  int last_err = 0;
  logic [NODE_W-1:0] ent [MAX_WP];

  path_follower #(
    .NODE_W(NODE_W), .MAX_WP(MAX_WP), .SENTINEL(SENTINEL),
    .MAX_NODE(MAX_NODE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .path_valid(path_valid), .path_in(path_in),
    .abort(abort), .wp_ready(wp_ready), .wp_valid(wp_valid), .wp_node(wp_node),
    .wp_index(wp_index), .wp_last(wp_last), .path_len(path_len), .busy(busy),
    .follow_done(follow_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the path from entry 0 and classify it.
  // kind 0 = ok, 1 = empty, 2 = bad node. scan = cycles spent scanning.
  function automatic void model(output int kind, output int len, output int scan);
    kind = 0;
    len  = MAX_WP;
    scan = MAX_WP;
    for (int i = 0; i < MAX_WP; i++) begin
      if (ent[i] == SENTINEL) begin
        len  = i;
        scan = i + 1;
        kind = (i == 0) ? 1 : 0;
        return;
      end
      if (ent[i] > MAX_NODE) begin
        kind = 2;
        scan = i + 1;
        return;
      end
    end
  endfunction

  task automatic start_path(input bit ab, output int kind, output int len);
    int scan;
    int step;
    model(kind, len, scan);
    for (int i = 0; i < MAX_WP; i++) path_in[i*NODE_W +: NODE_W] = ent[i];
    wp_ready   = 1'b0;
    path_valid = 1'b1;
    abort      = ab;
    cyc();
    path_valid = 1'b0;
    abort      = 1'b0;
    step = 1;
    vec++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL capture_busy: busy=%0b expected 1", busy);
    end
    while (wp_valid !== 1'b1 && err !== 1'b1 && step < 40) begin
      cyc();
      step++;
    end
    vec++;
    if (step != scan + 1) begin
      errs++; $display("FAIL scan_latency: event at cycle %0d expected %0d", step, scan + 1);
    end
    if (kind != 0) begin
      vec++;
      if (err !== 1'b1 || err_code !== 2'(kind) || wp_valid !== 1'b0) begin
        errs++; $display("FAIL err_report: err=%0b code=%0d wp_valid=%0b expected 1/%0d/0",
                         err, err_code, wp_valid, kind);
      end
      vec++;
      if (path_len !== 4'(last_len)) begin
        errs++; $display("FAIL path_len_held: got %0d expected %0d", path_len, last_len);
      end
      last_err = kind;
      cyc();
      vec++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL err_pulse_end: err=%0b busy=%0b expected 0/0", err, busy);
      end
    end else begin
      vec++;
      if (path_len !== 4'(len)) begin
        errs++; $display("FAIL path_len: got %0d expected %0d", path_len, len);
      end
      last_len = len;
    end
  endtask

  // mode 0: ready high except stall_n cycles on waypoint stall_wp; mode 1: random
  task automatic run_path(input int mode, input int stall_wp, input int stall_n,
                          input bit glitch, input bit ab);
    int kind, len, i, stalls, guard;
    bit rdy;
    start_path(ab, kind, len);
    if (kind != 0) return;
    i = 0; stalls = 0; guard = 0;
    while (i < len && guard < 300) begin
      vec++;
      if (wp_valid !== 1'b1 || wp_node !== ent[len-1-i] || wp_index !== 4'(i) ||
          wp_last !== (i == len - 1)) begin
        errs++; $display("FAIL waypoint %0d: valid=%0b node=%0d idx=%0d last=%0b expected 1/%0d/%0d/%0b",
                         i, wp_valid, wp_node, wp_index, wp_last, ent[len-1-i], i, (i == len - 1));
      end
      if (mode == 1) rdy = (stalls >= 5) || ($urandom_range(0, 2) != 0);
      else           rdy = !(i == stall_wp && stalls < stall_n);
      wp_ready = rdy;
      if (glitch && i == 1) begin
        path_in    = '1;
        path_valid = 1'b1;
      end else begin
        path_valid = 1'b0;
      end
      cyc();
      if (rdy) begin i++; stalls = 0; end
      else stalls++;
      guard++;
    end
    wp_ready   = 1'b0;
    path_valid = 1'b0;
    vec++;
    if (i != len) begin
      errs++; $display("FAIL emit_budget: accepted %0d of %0d", i, len);
    end
    vec++;
    if (follow_done !== 1'b1 || wp_valid !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL done_pulse: done=%0b valid=%0b busy=%0b expected 1/0/1",
                       follow_done, wp_valid, busy);
    end
    cyc();
    vec++;
    if (follow_done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errs++; $display("FAIL back_to_idle: done=%0b busy=%0b err=%0b expected 0/0/0",
                       follow_done, busy, err);
    end
    vec++;
    if (err_code !== 2'(last_err)) begin
      errs++; $display("FAIL err_code_held: got %0d expected %0d", err_code, last_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    vec++;
    if ({wp_valid, wp_node, wp_index, wp_last, path_len, busy, follow_done, err, err_code} !== '0) begin
      errs++; $display("FAIL reset_outputs: valid=%0b node=%0d idx=%0d last=%0b len=%0d busy=%0b done=%0b err=%0b code=%0d expected all 0",
                       wp_valid, wp_node, wp_index, wp_last, path_len, busy, follow_done, err, err_code);
    end
    rst_n = 1'b1;
    last_len = 0; last_err = 0;
    cyc();
    vec++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL reset_idle: busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_example();
    ent = '{5'd8, 5'd9, 5'd5, 5'd2, 5'd1, 5'd0, 5'd27, 5'bx, 5'bx, 5'bx};
    run_path(0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_short_paths();
    int kind, len;
    ent = '{5'd0, 5'd27, 5'bx, 5'bx, 5'bx, 5'bx, 5'bx, 5'bx, 5'bx, 5'bx};
    run_path(0, -1, 0, 1'b0, 1'b0);
    ent = '{5'd27, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd1, 5'd2};
    start_path(1'b0, kind, len);
  endtask

  task automatic test_full_and_bad();
    int kind, len;
    ent = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd17, 5'd25};
    run_path(0, -1, 0, 1'b0, 1'b0);
    ent = '{5'd1, 5'd2, 5'd3, 5'd30, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    start_path(1'b0, kind, len);
  endtask

  task automatic test_backpressure();
    ent = '{5'd4, 5'd14, 5'd24, 5'd20, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_path(0, 2, 5, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int kind, len, n;
    ent = '{5'd5, 5'd6, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    start_path(1'b0, kind, len);
    wp_ready = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      vec++;
      if (wp_valid !== 1'b1 || wp_node !== ent[len-1] || wp_index !== 4'd0) begin
        errs++; $display("FAIL stall_hold: valid=%0b node=%0d idx=%0d expected 1/%0d/0",
                         wp_valid, wp_node, wp_index, ent[len-1]);
      end
      cyc();
      n++;
    end
    vec++;
    if (n != TIMEOUT) begin
      errs++; $display("FAIL timeout_cycles: err after %0d cycles expected %0d", n, TIMEOUT);
    end
    vec++;
    if (err_code !== 2'b11 || wp_valid !== 1'b0) begin
      errs++; $display("FAIL timeout_code: code=%0d valid=%0b expected 3/0", err_code, wp_valid);
    end
    last_err = 3;
    cyc();
    vec++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errs++; $display("FAIL timeout_idle: busy=%0b err=%0b expected 0/0", busy, err);
    end
  endtask

  task automatic test_abort();
    int kind, len;
    ent = '{5'd7, 5'd3, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    start_path(1'b0, kind, len);
    wp_ready = 1'b1;
    cyc();
    vec++;
    if (wp_valid !== 1'b1 || wp_last !== 1'b1 || wp_node !== 5'd7) begin
      errs++; $display("FAIL abort_setup: valid=%0b last=%0b node=%0d expected 1/1/7", wp_valid, wp_last, wp_node);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0; wp_ready = 1'b0;
    vec++;
    if (wp_valid !== 1'b0 || busy !== 1'b0 || follow_done !== 1'b0 || err !== 1'b0) begin
      errs++; $display("FAIL abort_last: valid=%0b busy=%0b done=%0b err=%0b expected 0/0/0/0",
                       wp_valid, busy, follow_done, err);
    end
    cyc();
    vec++;
    if (follow_done !== 1'b0 || err !== 1'b0) begin
      errs++; $display("FAIL abort_quiet: done=%0b err=%0b expected 0/0", follow_done, err);
    end
    // abort while scanning
    ent = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
    for (int i = 0; i < MAX_WP; i++) path_in[i*NODE_W +: NODE_W] = ent[i];
    path_valid = 1'b1;
    cyc();
    path_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    vec++;
    if (busy !== 1'b0 || err !== 1'b0 || wp_valid !== 1'b0) begin
      errs++; $display("FAIL abort_scan: busy=%0b err=%0b valid=%0b expected 0/0/0", busy, err, wp_valid);
    end
    // abort while idle is ignored, including on the capture cycle; path_valid mid-EMIT too
    ent = '{5'd12, 5'd22, 5'd2, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_path(0, -1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int kind, len;
    ent = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    start_path(1'b0, kind, len);
    wp_ready = 1'b1;
    cyc();
    wp_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    vec++;
    if ({wp_valid, wp_node, wp_index, wp_last, path_len, busy, follow_done, err, err_code} !== '0) begin
      errs++; $display("FAIL reset_mid: valid=%0b node=%0d idx=%0d last=%0b len=%0d busy=%0b done=%0b err=%0b code=%0d expected all 0",
                       wp_valid, wp_node, wp_index, wp_last, path_len, busy, follow_done, err, err_code);
    end
    rst_n = 1'b1;
    last_len = 0; last_err = 0;
    ent = '{5'd9, 5'd10, 5'd11, 5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_path(0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, MAX_WP);
      for (int i = 0; i < MAX_WP; i++) ent[i] = 5'($urandom_range(0, MAX_NODE));
      if (r < MAX_WP) begin
        ent[r] = 5'(SENTINEL);
        for (int i = r + 1; i < MAX_WP; i++) ent[i] = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 5) == 0) ent[$urandom_range(0, MAX_WP - 1)] = 5'($urandom_range(MAX_NODE + 1, 31));
      run_path(1, -1, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_short_paths();
    test_full_and_bad();
    test_backpressure();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
